// File: rtl/skip_ctrl.sv
// Conditional-skip controller: evaluates an execute-stage skip condition and nullifies the
// following 1..2^LEN_W valid instructions, keeping a saturating count of taken skips.
module skip_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = $clog2(WIDTH),
  parameter int unsigned LEN_W = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       opcode,
  input  logic [SEL_W-1:0] selector,
  input  logic             direction,
  input  logic [LEN_W-1:0] skip_len,
  input  logic [WIDTH-1:0] reg_value,
  input  logic [WIDTH-1:0] accum_value,
  input  logic             clear_stats,
  output logic             cond,
  output logic             squash,
  output logic             busy,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] OpTest    = 4'b1010;
  localparam logic [3:0] OpBitSet  = 4'b1011;
  localparam logic [3:0] OpBitClr  = 4'b1100;
  localparam logic [3:0] OpCompare = 4'b1101;

  logic [LEN_W:0]   remaining_q, remaining_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] range_vec;
  logic [2:0]       sel3;
  logic             sel_bit;
  logic             sel_in_range;
  logic             v_neg;
  logic             v_zero;
  logic             cmp_eq;
  logic             cmp_slt;
  logic             cmp_ult;
  logic             is_skip_op;
  logic             accept;
  logic             advance;

  // Condition evaluation
  always_comb begin
    operand      = direction ? reg_value : accum_value;
    v_neg        = operand[WIDTH-1];
    v_zero       = (operand == '0);
    sel3         = 3'(selector);
    shifted      = operand >> selector;
    sel_bit      = shifted[0];
    // Bit 0 of an all-ones vector survives the shift only while selector < WIDTH.
    range_vec    = {WIDTH{1'b1}} >> selector;
    sel_in_range = range_vec[0];
    cmp_eq       = (reg_value == accum_value);
    cmp_slt      = ($signed(reg_value) < $signed(accum_value));
    cmp_ult      = (reg_value < accum_value);

    cond = 1'b0;
    case (opcode)
      OpTest: begin
        case (sel3)
          3'b000:  cond = v_zero;
          3'b001:  cond = !v_zero;
          3'b010:  cond = v_neg;
          3'b011:  cond = !v_neg;
          3'b100:  cond = !v_neg && !v_zero;
          default: cond = v_neg || v_zero;
        endcase
      end
      OpBitSet: cond = sel_in_range && sel_bit;
      OpBitClr: cond = sel_in_range && !sel_bit;
      OpCompare: begin
        case (sel3)
          3'b000:  cond = cmp_eq;
          3'b001:  cond = !cmp_eq;
          3'b010:  cond = cmp_slt;
          3'b011:  cond = !cmp_slt;
          3'b100:  cond = cmp_ult;
          3'b101:  cond = !cmp_ult;
          default: cond = 1'b0;
        endcase
      end
      default: cond = 1'b0;
    endcase
  end

  assign busy       = (remaining_q != '0);
  assign squash     = valid && busy;
  assign is_skip_op = (opcode == OpTest) || (opcode == OpBitSet) ||
                      (opcode == OpBitClr) || (opcode == OpCompare);
  assign advance    = valid && !stall && !flush;
  // A squashed instruction is never evaluated, so it cannot open a new window.
  assign accept     = advance && !squash && cond && is_skip_op;

  // Skip window and statistics next state
  always_comb begin
    remaining_d = remaining_q;
    if (flush) begin
      remaining_d = '0;
    end else if (advance && squash) begin
      remaining_d = remaining_q - (LEN_W + 1)'(1);
    end else if (accept) begin
      remaining_d = {1'b0, skip_len} + (LEN_W + 1)'(1);
    end

    taken_d = accept;

    taken_cnt_d = taken_cnt_q;
    if (clear_stats) begin
      taken_cnt_d = '0;
    end else if (accept && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining_q <= '0;
      taken_q     <= 1'b0;
      taken_cnt_q <= '0;
    end else begin
      remaining_q <= remaining_d;
      taken_q     <= taken_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken     = taken_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_skip_ctrl.sv
// Directed bench for skip_ctrl: two instances (8-bit/2-bit counter and 16-bit/16-bit counter)
// checked every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_skip_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid, stall, flush, dir, clr;
  logic [3:0]  op, sel;
  logic [1:0]  len;
  logic [15:0] r16, a16;

  logic        cond_a, squash_a, busy_a, taken_a;
  logic [1:0]  cnt_a;
  logic        cond_b, squash_b, busy_b, taken_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: index 0 = 8-bit instance, 1 = 16-bit instance
  int unsigned m_rem[2];
  bit          m_taken[2];
  longint      m_cnt[2];
  int          m_w[2]    = '{8, 16};
  longint      m_cmax[2] = '{3, 65535};

  always #5 clk = ~clk;

  skip_ctrl #(.WIDTH(8), .SEL_W(4), .LEN_W(2), .CNT_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .valid(valid), .stall(stall), .flush(flush),
    .opcode(op), .selector(sel), .direction(dir), .skip_len(len),
    .reg_value(r16[7:0]), .accum_value(a16[7:0]), .clear_stats(clr),
    .cond(cond_a), .squash(squash_a), .busy(busy_a), .taken(taken_a), .taken_cnt(cnt_a)
  );

  skip_ctrl #(.WIDTH(16), .LEN_W(2), .CNT_W(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .valid(valid), .stall(stall), .flush(flush),
    .opcode(op), .selector(sel), .direction(dir), .skip_len(len),
    .reg_value(r16), .accum_value(a16), .clear_stats(clr),
    .cond(cond_b), .squash(squash_b), .busy(busy_b), .taken(taken_b), .taken_cnt(cnt_b)
  );

  function automatic longint to_signed(longint unsigned v, int w);
    if (v >= (64'd1 << (w - 1))) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  function automatic bit m_cond(int w, logic [3:0] o, logic [3:0] s, logic d,
                                longint unsigned r, longint unsigned a);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned ru = r & mask;
    longint unsigned au = a & mask;
    longint unsigned v = d ? ru : au;
    longint sv = to_signed(v, w);
    longint sr = to_signed(ru, w);
    longint sa = to_signed(au, w);
    int unsigned s3 = int'(s) % 8;
    case (o)
      4'hA: case (s3)
              0: return v == 0;
              1: return v != 0;
              2: return sv < 0;
              3: return sv >= 0;
              4: return sv > 0;
              default: return sv <= 0;
            endcase
      4'hB: return (int'(s) < w) && (((v >> s) & 1) == 1);
      4'hC: return (int'(s) < w) && (((v >> s) & 1) == 0);
      4'hD: case (s3)
              0: return ru == au;
              1: return ru != au;
              2: return sr < sa;
              3: return sr >= sa;
              4: return ru < au;
              5: return ru >= au;
              default: return 1'b0;
            endcase
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    bit c0 = m_cond(8, op, sel, dir, r16, a16);
    bit c1 = m_cond(16, op, sel, dir, r16, a16);
    chk("cond_a", cond_a, c0);
    chk("squash_a", squash_a, valid && (m_rem[0] != 0));
    chk("busy_a", busy_a, m_rem[0] != 0);
    chk("taken_a", taken_a, m_taken[0]);
    chk("cnt_a", cnt_a, m_cnt[0]);
    chk("cond_b", cond_b, c1);
    chk("squash_b", squash_b, valid && (m_rem[1] != 0));
    chk("busy_b", busy_b, m_rem[1] != 0);
    chk("taken_b", taken_b, m_taken[1]);
    chk("cnt_b", cnt_b, m_cnt[1]);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0;
      m_taken[k] = 0;
      m_cnt[k] = 0;
    end
  endtask

  task automatic model_update();
    if (!reset_n) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit c  = m_cond(m_w[k], op, sel, dir, r16, a16);
      bit sq = valid && (m_rem[k] != 0);
      bit acc = valid && !stall && !flush && !sq && c && (op >= 4'hA) && (op <= 4'hD);
      if (flush) m_rem[k] = 0;
      else if (valid && !stall && sq) m_rem[k] = m_rem[k] - 1;
      else if (acc) m_rem[k] = int'(len) + 1;
      m_taken[k] = acc;
      if (clr) m_cnt[k] = 0;
      else if (acc && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] o,
                       input logic [3:0] s, input logic d, input logic [1:0] l,
                       input logic [15:0] r, input logic [15:0] a, input logic c);
    valid = v; stall = st; flush = fl; op = o; sel = s; dir = d; len = l;
    r16 = r; a16 = a; clr = c;
  endtask

  task automatic nop();
    drive(1, 0, 0, 4'h0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] rv[4] = '{16'h0000, 16'h8001, 16'h00FF, 16'hFFFF};
  logic [15:0] av[4] = '{16'h0000, 16'h7FFF, 16'hFF00, 16'h0001};
  logic [3:0]  ops[5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
  logic [1:0]  exp_sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_taken", taken_a, 0);
    chk("rst_cnt", cnt_b, 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Sign test on reg_value, one-instruction skip
    drive(1, 0, 0, 4'hA, 4'd2, 1, 2'd0, 16'h0080, 16'h0, 0);
    #1;
    chk("neg_cond", cond_a, 1);
    chk("neg_squash", squash_a, 0);
    tick();
    chk("neg_taken", taken_a, 1);
    chk("neg_busy", busy_a, 1);
    chk("neg_cnt", cnt_a, 1);
    nop(); #1;
    chk("skip1_squash", squash_a, 1);
    tick();
    chk("skip1_busy", busy_a, 0);
    nop(); #1;
    chk("skip1_after", squash_a, 0);
    tick();

    // Compare mode, unsigned vs signed on the 16-bit instance
    drive(0, 0, 0, 4'hD, 4'd4, 0, 0, 16'h0001, 16'hFFFF, 0); #1;
    chk("cmp_ult", cond_b, 1);
    tick();
    drive(0, 0, 0, 4'hD, 4'd2, 0, 0, 16'h0001, 16'hFFFF, 0); #1;
    chk("cmp_slt", cond_b, 0);
    tick();
    drive(0, 0, 0, 4'hD, 4'd3, 0, 0, 16'h0001, 16'hFFFF, 0); #1;
    chk("cmp_sge", cond_b, 1);
    tick();

    // Condition sweep without issuing (state must hold)
    for (int o = 0; o < 5; o++)
      for (int p = 0; p < 4; p++)
        for (int s = 0; s < 16; s++) begin
          drive(0, 0, 0, ops[o], 4'(s), 1'(s ^ p), 0, rv[p], av[p], 0);
          tick();
        end

    // Bit index beyond operand width
    drive(0, 0, 0, 4'hB, 4'd9, 1, 0, 16'hFFFF, 16'h0, 0); #1;
    chk("bit_oob_a", cond_a, 0);
    chk("bit_in_b", cond_b, 1);
    tick();
    drive(0, 0, 0, 4'hC, 4'd9, 1, 0, 16'h0000, 16'h0, 0); #1;
    chk("bclr_oob_a", cond_a, 0);
    chk("bclr_in_b", cond_b, 1);
    tick();

    // skip_len 2 with bubble and stall in the window
    drive(1, 0, 0, 4'hB, 4'd0, 1, 2'd2, 16'h0001, 16'h0, 0); tick();
    chk("w3_cnt", cnt_a, 2);
    nop(); #1; chk("w3_slot1", squash_a, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("w3_bubble_sq", squash_a, 0);
    chk("w3_bubble_busy", busy_a, 1);
    tick();
    nop(); #1; chk("w3_slot2", squash_a, 1); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    chk("w3_stall_busy", busy_a, 1);
    nop(); #1; chk("w3_slot3", squash_a, 1); tick();
    chk("w3_busy_drop", busy_a, 0);
    nop(); #1; chk("w3_slot4", squash_a, 0); tick();

    // Flush inside the window
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    chk("clr_a", cnt_a, 0);
    drive(1, 0, 0, 4'hB, 4'd0, 1, 2'd3, 16'h0001, 16'h0, 0); tick();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("fl_squash", squash_a, 1);
    tick();
    chk("fl_busy", busy_a, 0);
    nop(); #1;
    chk("fl_next", squash_a, 0);
    chk("fl_cnt_a", cnt_a, 1);
    chk("fl_cnt_b", cnt_b, 1);
    tick();

    // Squashed skip opcode with a true condition is not evaluated
    drive(1, 0, 0, 4'hB, 4'd0, 1, 2'd1, 16'h0001, 16'h0, 0); tick();
    drive(1, 0, 0, 4'hB, 4'd0, 1, 2'd0, 16'h0001, 16'h0, 0); #1;
    chk("sqop_squash", squash_a, 1);
    tick();
    chk("sqop_taken", taken_a, 0);
    chk("sqop_cnt", cnt_a, 2);
    chk("sqop_busy", busy_a, 1);
    nop(); tick();
    chk("sqop_drop", busy_a, 0);

    // Flush or stall block an otherwise accepted skip
    drive(1, 0, 1, 4'hB, 4'd0, 1, 2'd0, 16'h0001, 16'h0, 0); tick();
    chk("fl_acc_taken", taken_a, 0);
    drive(1, 1, 0, 4'hB, 4'd0, 1, 2'd0, 16'h0001, 16'h0, 0); tick();
    chk("st_acc_busy", busy_a, 0);

    // Saturation of the 2-bit counter, then clear beats accept
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 4'hA, 4'd1, 0, 2'd0, 16'h0, 16'h0005, 0); tick();
      chk("sat_a", cnt_a, exp_sat[i]);
      chk("sat_b", cnt_b, i + 1);
      nop(); tick();
    end
    drive(1, 0, 0, 4'hA, 4'd1, 0, 2'd0, 16'h0, 16'h0005, 1); tick();
    chk("clr_acc_cnt", cnt_a, 0);
    chk("clr_acc_taken", taken_a, 1);
    chk("clr_acc_busy", busy_a, 1);

    // Reset mid-window abandons it
    nop();
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_squash", squash_b, 0);
    chk("mid_rst_taken", taken_a, 0);
    tick();
    reset_n = 1'b1;
    nop(); #1;
    chk("post_rst_sq", squash_a, 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
